// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register file: FSM state encoding,
// default bus widths, default target address and a majority-vote helper
// used by the optional glitch filter.
package i2c_pkg;

    localparam int         DEF_ADDR_WIDTH    = 7;
    localparam int         DEF_DATA_WIDTH    = 8;
    localparam logic [6:0] DEF_SLAVE_ADDRESS = 7'h22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Bus line conditioning for the scl/sda pair: 2-flop synchronizers, an
// optional 3-sample majority glitch filter (enabled by defining
// I2C_TARGET_GLITCH_FILTER_EN), and scl edge / START / STOP detection.
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_c;
    logic       sda_c;
    logic       scl_q;
    logic       sda_q;

    // Two-flop synchronizers; idle bus level is high so they reset to 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;

    // Three-sample history; a single-cycle pulse never wins the vote.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end

    assign scl_c = maj3(scl_hist);
    assign sda_c = maj3(sda_hist);
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    // Previous conditioned levels for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_c;
            sda_q <= sda_c;
        end
    end

    assign sda      = sda_c;
    assign scl_rise = scl_c & ~scl_q;
    assign scl_fall = ~scl_c & scl_q;
    assign start    = scl_c & scl_q & sda_q & ~sda_c;
    assign stop     = scl_c & scl_q & ~sda_q & sda_c;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a small register file. First written byte after the
// address sets the pointer; further bytes write and auto-increment. Reads
// stream from the pointer until the master NACKs. Optional glitch filter
// on the bus lines is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | bus free or after STOP, sda released
// ADDR     | shifting in address + R/W after START
// ADDR_ACK | own address matched, driving ACK on 9th clock
// WR_BYTE  | shifting in pointer or data byte from master
// WR_ACK   | driving ACK for received byte
// RD_BYTE  | shifting out mem[ptr] MSB first
// RD_ACK   | sda released, sampling master ACK/NACK
// IGNORE   | not addressed or read ended, waiting for START/STOP
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                        I2C_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = I2C_ADDR_WIDTH'(DEF_SLAVE_ADDRESS),
    parameter int                        MEM_DEPTH      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         scl_i,
    input  logic                         sda_i,
    output logic                         scl_o,
    output logic                         sda_o,
    output logic                         busy_o,
    output logic                         wr_stb_o,
    output logic [$clog2(MEM_DEPTH)-1:0] wr_ptr_o,
    output logic [I2C_DATA_WIDTH-1:0]    wr_dat_o
);

    localparam int         PW        = $clog2(MEM_DEPTH);
    localparam int         DW        = I2C_DATA_WIDTH;
    localparam logic [3:0] ADDR_BITS = 4'(I2C_ADDR_WIDTH + 1);
    localparam logic [3:0] BYTE_BITS = 4'(DW);

    logic          sda;
    logic          scl_rise;
    logic          scl_fall;
    logic          start;
    logic          stop;

    i2c_state_t    state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [DW-1:0] shreg, shreg_n;
    logic [PW-1:0] ptr, ptr_n;
    logic          sda_r, sda_n;
    logic          busy_r, busy_n;
    logic          first, first_n;
    logic          rw, rw_n;
    logic          ack_bit, ack_n;
    logic          we;

    logic [DW-1:0] mem [MEM_DEPTH];
    logic [DW-1:0] mem_cur;
    logic [DW-1:0] mem_nxt;

    i2c_line_cond u_line_cond (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign mem_cur = mem[ptr];
    assign mem_nxt = mem[ptr + PW'(1)];

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state and datapath updates; START/STOP override any byte in flight.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ptr_n   = ptr;
        sda_n   = sda_r;
        busy_n  = busy_r;
        first_n = first;
        rw_n    = rw;
        ack_n   = ack_bit;
        we      = 1'b0;
        if (start) begin
            state_n = ST_ADDR;
            cnt_n   = '0;
            sda_n   = 1'b1;
            busy_n  = 1'b0;
        end else if (stop) begin
            state_n = ST_IDLE;
            sda_n   = 1'b1;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_n = {shreg[DW-2:0], sda};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == ADDR_BITS) begin
                        if (shreg[I2C_ADDR_WIDTH:1] == SLAVE_ADDRESS) begin
                            state_n = ST_ADDR_ACK;
                            sda_n   = 1'b0;
                            busy_n  = 1'b1;
                            rw_n    = shreg[0];
                        end else begin
                            state_n = ST_IGNORE;
                            sda_n   = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n = '0;
                        if (rw) begin
                            state_n = ST_RD_BYTE;
                            sda_n   = mem_cur[DW-1];
                            shreg_n = {mem_cur[DW-2:0], 1'b0};
                        end else begin
                            state_n = ST_WR_BYTE;
                            sda_n   = 1'b1;
                            first_n = 1'b1;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_n = {shreg[DW-2:0], sda};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == BYTE_BITS) begin
                        state_n = ST_WR_ACK;
                        sda_n   = 1'b0;
                        if (first) begin
                            ptr_n   = shreg[PW-1:0];
                            first_n = 1'b0;
                        end else begin
                            we    = 1'b1;
                            ptr_n = ptr + PW'(1);
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_n = ST_WR_BYTE;
                        sda_n   = 1'b1;
                        cnt_n   = '0;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == BYTE_BITS) begin
                            state_n = ST_RD_ACK;
                            sda_n   = 1'b1;
                        end else begin
                            sda_n   = shreg[DW-1];
                            shreg_n = {shreg[DW-2:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_n = sda;
                    end else if (scl_fall) begin
                        if (!ack_bit) begin
                            state_n = ST_RD_BYTE;
                            ptr_n   = ptr + PW'(1);
                            cnt_n   = '0;
                            sda_n   = mem_nxt[DW-1];
                            shreg_n = {mem_nxt[DW-2:0], 1'b0};
                        end else begin
                            state_n = ST_IGNORE;
                            sda_n   = 1'b1;
                        end
                    end
                end
                default: sda_n = 1'b1;
            endcase
        end
    end

    // Datapath and output registers; reset releases sda asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            shreg    <= '0;
            ptr      <= '0;
            sda_r    <= 1'b1;
            busy_r   <= 1'b0;
            first    <= 1'b0;
            rw       <= 1'b0;
            ack_bit  <= 1'b1;
            wr_stb_o <= 1'b0;
            wr_ptr_o <= '0;
            wr_dat_o <= '0;
        end else begin
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            ptr      <= ptr_n;
            sda_r    <= sda_n;
            busy_r   <= busy_n;
            first    <= first_n;
            rw       <= rw_n;
            ack_bit  <= ack_n;
            wr_stb_o <= we;
            if (we) begin
                wr_ptr_o <= ptr;
                wr_dat_o <= shreg;
            end
        end
    end

    // Register file storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[ptr] <= shreg;
        end
    end

    assign scl_o  = 1'b1;
    assign sda_o  = sda_r;
    assign busy_o = busy_r;

endmodule
